pipo_wr_arb: RTL



---
 rtl/pipo_wr_arb_pkg.sv | 14 +
 rtl/pipo_wr_arb_if.sv | 37 +++
 rtl/pipo_wr_arb_rr_pick.sv | 54 +++++
 rtl/pipo_wr_arb.sv | 108 ++++++++++
 4 files changed

// File: rtl/pipo_wr_arb_pkg.sv
// Shared types and default sizes for the PIPO write arbiter.
// Holds the FSM state enum and the W/R parameter defaults.
package pipo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } arb_state_t;

   localparam int W_DEF = 8;
   localparam int R_DEF = 4;

endpackage

// File: rtl/pipo_wr_arb_if.sv
// Requester-side bus of the PIPO write arbiter.
// req/data: requests and flattened words (word i at [i*W +: W]);
// gnt/ack: one-hot grant and acknowledge; q: register; busy.
// master = requester side, slave = arbiter side.
interface pipo_wr_arb_if
   import pipo_arb_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int R = R_DEF
) ();

   logic [R-1:0]   req;
   logic [R*W-1:0] data;
   logic [R-1:0]   gnt;
   logic [R-1:0]   ack;
   logic [W-1:0]   q;
   logic           busy;

   modport master (
      output req,
      output data,
      input  gnt,
      input  ack,
      input  q,
      input  busy
   );

   modport slave (
      input  req,
      input  data,
      output gnt,
      output ack,
      output q,
      output busy
   );

endinterface

// File: rtl/pipo_wr_arb_rr_pick.sv
// Combinational winner picker for the PIPO write arbiter.
// In: req, ptr (round-robin start). Out: one-hot oh, binary idx.
// PIPO_ARB_FIXED_PRIO_EN: no ptr port, lowest active index wins.
module rr_pick
   import pipo_arb_pkg::*;
#(
   parameter int R = R_DEF
) (
   input  logic [R-1:0]         req,
`ifndef PIPO_ARB_FIXED_PRIO_EN
   input  logic [$clog2(R)-1:0] ptr,
`endif
   output logic [R-1:0]         oh,
   output logic [$clog2(R)-1:0] idx
);

   localparam int IW = $clog2(R);

`ifdef PIPO_ARB_FIXED_PRIO_EN

   // Scan high to low so the lowest active index is the last write.
   always_comb begin
      oh  = '0;
      idx = '0;
      for (int i = R - 1; i >= 0; i--) begin
         if (req[i]) begin
            oh     = '0;
            oh[i]  = 1'b1;
            idx    = IW'(i);
         end
      end
   end

`else

   // Scan offsets from far to near so offset 0 (ptr) has the last word.
   always_comb begin
      int j;
      oh  = '0;
      idx = '0;
      j   = 0;
      for (int k = R - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % R;
         if (req[j]) begin
            oh    = '0;
            oh[j] = 1'b1;
            idx   = IW'(j);
         end
      end
   end

`endif

endmodule

// File: rtl/pipo_wr_arb.sv
// Round-robin write arbiter and sequencer for a shared PIPO register.
// Ports: CLK, n_res (async active-low), bus (slave: req, data, gnt,
// ack, q, busy). Define PIPO_ARB_FIXED_PRIO_EN for fixed priority.
module pipo_wr_arb
   import pipo_arb_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int R = R_DEF
) (
   input  logic         CLK,
   input  logic         n_res,
   pipo_wr_arb_if.slave bus
);

   localparam int IW = $clog2(R);

   arb_state_t    state;
   arb_state_t    nstate;
   logic [R-1:0]  pick_oh;
   logic [IW-1:0] pick_idx;
   logic [R-1:0]  w_oh;
   logic [IW-1:0] w_idx;
   logic [W-1:0]  q_r;

`ifndef PIPO_ARB_FIXED_PRIO_EN
   logic [IW-1:0] ptr;
`endif

   rr_pick #(
      .R   (R)
   ) u_pick (
      .req (bus.req),
`ifndef PIPO_ARB_FIXED_PRIO_EN
      .ptr (ptr),
`endif
      .oh  (pick_oh),
      .idx (pick_idx)
   );

   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   // gnt/ack decode from state only, so reset clears them at once.
   always_comb begin
      nstate   = state;
      bus.gnt  = '0;
      bus.ack  = '0;
      bus.busy = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               nstate = WRITE;
            end
         end
         WRITE: begin
            bus.gnt  = w_oh;
            bus.busy = 1'b1;
            nstate   = ACK;
         end
         ACK: begin
            bus.ack  = w_oh;
            bus.busy = 1'b1;
            nstate   = IDLE;
         end
         default: begin
            nstate = IDLE;
         end
      endcase
   end

   // Winner is frozen in IDLE; req changes later cannot redirect it.
   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         w_oh  <= '0;
         w_idx <= '0;
      end else if (state == IDLE && |bus.req) begin
         w_oh  <= pick_oh;
         w_idx <= pick_idx;
      end
   end

   // The PIPO register: loads only on the edge that ends WRITE.
   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         q_r <= '0;
      end else if (state == WRITE) begin
         q_r <= bus.data[int'(w_idx) * W +: W];
      end
   end

`ifndef PIPO_ARB_FIXED_PRIO_EN
   always_ff @(posedge CLK or negedge n_res) begin
      if (!n_res) begin
         ptr <= '0;
      end else if (state == WRITE) begin
         ptr <= (w_idx == IW'(R - 1)) ? '0 : w_idx + 1'b1;
      end
   end
`endif

   assign bus.q = q_r;

endmodule
